// File: rtl/four_bit_modified_comparator.sv
// Registered 4-bit unsigned max-select: MSB-first cascaded comparator feeding a 2:1 mux and output register.
// R = max(A, B) one clock after the operands are presented; ties select A.
module four_bit_modified_comparator (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] R
);

  logic [3:0] gt;
  logic [3:0] eq;
  logic [3:0] gt_term;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_lt_b;
  logic [3:0] r_next;
  logic [3:0] r_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_slice
      assign gt[gi] = A[gi] & ~B[gi];
      assign eq[gi] = ~(A[gi] ^ B[gi]);
    end

    // A slice only decides the compare when every more-significant slice is equal.
    assign gt_term[3] = gt[3];
    for (gi = 0; gi < 3; gi++) begin : g_cascade
      assign gt_term[gi] = gt[gi] & (&eq[3:gi+1]);
    end
  endgenerate

  assign a_gt_b = |gt_term;
  assign a_eq_b = &eq;
  assign a_lt_b = ~a_gt_b & ~a_eq_b;

  assign r_next = a_lt_b ? B : A;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reg <= 4'b0000;
    end else begin
      r_reg <= r_next;
    end
  end

  assign R = r_reg;

endmodule

// File: tb/tb_four_bit_modified_comparator.sv
// Self-checking bench for four_bit_modified_comparator: directed, randomized and exhaustive
// stimulus checked against an arithmetic max() reference with a one-cycle register model.
module tb_four_bit_modified_comparator;

  logic       clk;
  logic       rst_n;
  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] R;

  int checks;
  int failures;

  four_bit_modified_comparator dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .R    (R)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] ref_max(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return m[3:0];
  endfunction

  task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Present operands away from the edge, clock once, then compare just after the edge.
  task automatic step(input string tag, input int a, input int b, input logic rst_val);
    logic [3:0] expected;
    @(negedge clk);
    A     = a[3:0];
    B     = b[3:0];
    rst_n = rst_val;
    @(posedge clk);
    #1;
    expected = rst_val ? ref_max(a, b) : 4'b0000;
    $display("txn %s rst_n=%b A=%0d B=%0d R=%0d exp=%0d", tag, rst_val, a, b, R, expected);
    check(tag, R, expected);
  endtask

  initial begin
    logic [3:0] held;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    A        = 4'b1111;
    B        = 4'b1111;

    step("reset_edge1", 15, 15, 1'b0);
    step("reset_edge2", 15, 15, 1'b0);
    step("reset_release", 5, 10, 1'b1);

    step("unsigned_10_5", 10, 5, 1'b1);
    step("unsigned_6_9", 6, 9, 1'b1);
    step("msb_12_3", 12, 3, 1'b1);
    step("msb_3_12", 3, 12, 1'b1);
    step("msb_7_14", 7, 14, 1'b1);
    step("cascade_3_5", 3, 5, 1'b1);
    step("cascade_2_4", 2, 4, 1'b1);
    step("cascade_12_10", 12, 10, 1'b1);
    step("equal_12", 12, 12, 1'b1);
    step("equal_8", 8, 8, 1'b1);

    // R must not follow A between edges.
    held = R;
    @(negedge clk);
    A = 4'b1111;
    #2;
    check("hold_between_edges", R, held);
    @(posedge clk);
    #1;
    check("hold_next_edge", R, ref_max(15, 8));

    for (int i = 0; i < 40; i++) begin
      step("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b1);
    end

    for (int i = 0; i < 256; i++) begin
      step("exhaustive", i / 16, i % 16, (i == 137) ? 1'b0 : 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
